csr_basic_periph: RTL and testbench
===================================

Name: csr_basic_periph

Overview:
- Combined CSR-bus peripheral holding three functions: the RISC-V cycle/time/instret counters, read-only identification CSRs (including a clock-frequency CSR), and a small software-writable output-pin register.
- Sits on the core's CSR side-bus beside other CSR peripherals.
- rdata/valid are zero when this block is not addressed, so the results of all peripherals can be OR-combined.

Parameters:
- KHZ, 1000, clock frequency in kHz, returned by the frequency CSR.
- ID_BASE_ADDR, 12'hFC0, address of the frequency CSR.
- PINS_BASE_ADDR, 12'hBC1, address of the pin register.
- PINS_COUNT, 1, number of output pins (1..32).
- PINS_RESET_VALUE, 0, pin register value after reset.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- read  in  1  CSR read strobe; applies to the address registered on the previous cycle.
- modify  in  3  CSR operation on the registered address: 3'b001 write, 3'b010 set bits, 3'b011 clear bits, any other value no-op.
- wdata  in  32  operand for modify.
- addr  in  12  CSR address; registered every cycle.
- rdata  out  32  read data, registered; zero when the block is not addressed.
- valid  out  1  registered; high when the read address was claimed by this block.
- retired  in  1  one instruction retired this cycle; increments instret.
- pins  out  PINS_COUNT  output pin register.

Behaviour:
- Address phase: q_addr <= addr every cycle.
- read and modify in cycle N+1 act on q_addr captured in cycle N.
- Read latency: if read is high and q_addr matches a CSR of this block, then on the next edge rdata <= value and valid <= 1. Otherwise rdata <= 0 and valid <= 0.
- Reset values: rdata=0, valid=0, cycle=0, instret=0, pins=PINS_RESET_VALUE, q_addr=0.
- 64-bit cycle counter: +1 every clock not in reset.
- Cycle counter addresses: low word at C00 and B00, high word at C80 and B80. Time also aliases it, at C01 (low) and C81 (high).
- 64-bit instret counter: +1 on every cycle where retired=1. Addresses: low word at C02 and B02, high word at C82 and B82.
- Counter width and wrap: the carry from the low word propagates into the high word in the same cycle. The counter wraps from all-ones to 0.
- Identification CSRs, read-only:
  - ID_BASE_ADDR returns KHZ.
  - F11 (mvendorid), F12 (marchid), F13 (mimpid) and F14 (mhartid) return 0.
  - Writes to these addresses are ignored.
- Pin register at PINS_BASE_ADDR:
  - modify write: pins <= wdata[PINS_COUNT-1:0].
  - modify set: pins <= pins | wdata.
  - modify clear: pins <= pins & ~wdata.
  - Reads return the value zero-extended to 32 bits.
  - Pin changes appear at the output on the edge after the modify cycle.
- Read-modify in the same cycle: rdata returns the old value, and the register takes the new value on the same edge.
- Address overlap: if PINS_BASE_ADDR or ID_BASE_ADDR equals another address of this block, the pin register has priority, then the ID CSR.
- Reset mid-operation: reset overrides any pending read or modify. valid is low in the cycle after reset is asserted.

Optional Feature:
- Macro: CSR_COUNTER_WRITE_EN.
- When defined:
  - Machine-mode counter addresses B00, B80, B02 and B82 accept write, set and clear on the selected 32-bit half.
  - A written half takes the written value; the written value has priority over that cycle's increment for that half.
  - The other half still receives a carry if one is generated.
- When undefined: all counters are read-only and modify to any counter address is ignored.
- User addresses C00–C82 are always read-only.

Test Plan:
- Reset, then addr=C00 at cycle N and read=1 at N+1 -> valid=1 at N+2, and rdata equals the number of clock edges since reset deasserted (pin this down at cycle-exact counts). A second read 10 cycles later returns a value 10 higher.
- Pulse retired for exactly 5 cycles, then read C02 -> 5; read C82 -> 0. Read F11 -> valid=1, rdata=0.
- With KHZ=1000, read FC0 -> 32'd1000, valid=1. Read an unclaimed address (e.g. 3FF) -> valid=0, rdata=0.
- PINS_COUNT=1, reset value 0: write 1 to BC1 -> pins=1. Clear with 1 -> pins=0. Set with 1 -> pins=1. Read BC1 -> 1. Assert rst -> pins=0.
- With CSR_COUNTER_WRITE_EN defined: write 32'hFFFF_FFFF to B02, then assert retired once -> reading B02 gives 0 and reading B82 gives 1.
- Without CSR_COUNTER_WRITE_EN: the same write to B02 is ignored and instret keeps counting from its prior value.

Source files
------------

// File: rtl/csr_basic_periph.sv
// CSR side-bus peripheral: cycle/time/instret counters, read-only ID CSRs and an output-pin register.
// Define CSR_COUNTER_WRITE_EN to make the machine-mode counter aliases (B00/B80/B02/B82) writable.
module csr_basic_periph #(
  parameter int unsigned KHZ              = 1000,
  parameter logic [11:0] ID_BASE_ADDR     = 12'hFC0,
  parameter logic [11:0] PINS_BASE_ADDR   = 12'hBC1,
  parameter int unsigned PINS_COUNT       = 1,
  parameter logic [31:0] PINS_RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read,
  input  logic [2:0]            modify,
  input  logic [31:0]           wdata,
  input  logic [11:0]           addr,
  output logic [31:0]           rdata,
  output logic                  valid,
  input  logic                  retired,
  output logic [PINS_COUNT-1:0] pins
);

  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_SET   = 3'b010;
  localparam logic [2:0] OP_CLEAR = 3'b011;

  function automatic logic [31:0] apply_op(input logic [2:0] op, input logic [31:0] old,
                                           input logic [31:0] operand);
    case (op)
      OP_WRITE: apply_op = operand;
      OP_SET:   apply_op = old | operand;
      OP_CLEAR: apply_op = old & ~operand;
      default:  apply_op = old;
    endcase
  endfunction

  logic [11:0]           q_addr;
  logic [63:0]           cycle, cycle_nxt;
  logic [63:0]           instret, instret_nxt;
  logic [PINS_COUNT-1:0] pins_nxt;
  logic [31:0]           pins_ext, pins_op, rd_val;
  logic                  hit_pins, hit_id, rd_hit, op_valid;

  assign op_valid = (modify == OP_WRITE) || (modify == OP_SET) || (modify == OP_CLEAR);
  assign hit_pins = (q_addr == PINS_BASE_ADDR);
  assign hit_id   = !hit_pins && (q_addr == ID_BASE_ADDR);

  // Read decode: pin register wins over the ID CSR, which wins over the fixed map.
  always_comb begin
    pins_ext = '0;
    pins_ext[PINS_COUNT-1:0] = pins;
    rd_hit = 1'b1;
    rd_val = '0;
    if (hit_pins) begin
      rd_val = pins_ext;
    end else if (hit_id) begin
      rd_val = 32'(KHZ);
    end else begin
      case (q_addr)
        12'hC00, 12'hB00, 12'hC01: rd_val = cycle[31:0];
        12'hC80, 12'hB80, 12'hC81: rd_val = cycle[63:32];
        12'hC02, 12'hB02:          rd_val = instret[31:0];
        12'hC82, 12'hB82:          rd_val = instret[63:32];
        12'hF11, 12'hF12,
        12'hF13, 12'hF14:          rd_val = '0;
        default:                   rd_hit = 1'b0;
      endcase
    end
  end

  always_comb begin
    pins_op  = apply_op(modify, pins_ext, wdata);
    pins_nxt = pins;
    if (hit_pins && op_valid) pins_nxt = pins_op[PINS_COUNT-1:0];
  end

  // A written half replaces its incremented value; the other half keeps the carry.
  always_comb begin
    cycle_nxt   = cycle + 64'd1;
    instret_nxt = retired ? instret + 64'd1 : instret;
`ifdef CSR_COUNTER_WRITE_EN
    if (op_valid && !hit_pins && !hit_id) begin
      case (q_addr)
        12'hB00: cycle_nxt[31:0]    = apply_op(modify, cycle[31:0], wdata);
        12'hB80: cycle_nxt[63:32]   = apply_op(modify, cycle[63:32], wdata);
        12'hB02: instret_nxt[31:0]  = apply_op(modify, instret[31:0], wdata);
        12'hB82: instret_nxt[63:32] = apply_op(modify, instret[63:32], wdata);
        default: ;
      endcase
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_addr  <= '0;
      rdata   <= '0;
      valid   <= 1'b0;
      cycle   <= '0;
      instret <= '0;
      pins    <= PINS_RESET_VALUE[PINS_COUNT-1:0];
    end else begin
      q_addr  <= addr;
      rdata   <= (read && rd_hit) ? rd_val : '0;
      valid   <= read && rd_hit;
      cycle   <= cycle_nxt;
      instret <= instret_nxt;
      pins    <= pins_nxt;
    end
  end

endmodule

// File: tb/tb_csr_basic_periph.sv
// Directed-vector bench for csr_basic_periph (default parameters; honours CSR_COUNTER_WRITE_EN).
module tb_csr_basic_periph;

  logic        clk = 1'b0;
  logic        rst, read, retired;
  logic [2:0]  modify;
  logic [31:0] wdata, rdata;
  logic [11:0] addr;
  logic        valid;
  logic [0:0]  pins;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic [31:0] v1, v2;

  csr_basic_periph #(
    .KHZ(1000),
    .ID_BASE_ADDR(12'hFC0),
    .PINS_BASE_ADDR(12'hBC1),
    .PINS_COUNT(1),
    .PINS_RESET_VALUE(32'd0)
  ) dut (
    .clk(clk), .rst(rst), .read(read), .modify(modify), .wdata(wdata),
    .addr(addr), .rdata(rdata), .valid(valid), .retired(retired), .pins(pins)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Address phase, then read/modify phase, then sample the registered result.
  task automatic access(input logic [11:0] a, input logic rd, input logic [2:0] op,
                        input logic [31:0] d);
    @(negedge clk);
    addr = a; read = 1'b0; modify = 3'b000;
    @(negedge clk);
    read = rd; modify = op; wdata = d;
    @(negedge clk);
    read = 1'b0; modify = 3'b000; wdata = '0;
  endtask

  initial begin
    rst = 1'b1; read = 1'b0; retired = 1'b0; modify = '0; wdata = '0; addr = '0;
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd1 - 32'd1);
    check("reset_pins", {31'd0, pins}, 32'd0);

    // Release at this negedge; the read edge is the third posedge after it.
    rst = 1'b0;
    access(12'hC00, 1'b1, 3'b000, '0);
    v1 = rdata;
    check("cycle_first", v1, 32'd2);
    check("cycle_first_valid", {31'd0, valid}, 32'd1);
    repeat (7) @(negedge clk);
    access(12'hC00, 1'b1, 3'b000, '0);
    v2 = rdata;
    check("cycle_second", v2, 32'd12);

    @(negedge clk);
    retired = 1'b1;
    repeat (5) @(negedge clk);
    retired = 1'b0;
    access(12'hC02, 1'b1, 3'b000, '0);
    check("instret_lo", rdata, 32'd5);
    access(12'hC82, 1'b1, 3'b000, '0);
    check("instret_hi", rdata, 32'd0);
    check("instret_hi_valid", {31'd0, valid}, 32'd1);
    access(12'hB02, 1'b1, 3'b000, '0);
    check("instret_alias", rdata, 32'd5);
    access(12'hF11, 1'b1, 3'b000, '0);
    check("mvendorid", rdata, 32'd0);
    check("mvendorid_valid", {31'd0, valid}, 32'd1);
    access(12'hFC0, 1'b1, 3'b000, '0);
    check("khz", rdata, 32'd1000);
    check("khz_valid", {31'd0, valid}, 32'd1);
    access(12'h3FF, 1'b1, 3'b000, '0);
    check("unclaimed_rdata", rdata, 32'd0);
    check("unclaimed_valid", {31'd0, valid}, 32'd0);
    access(12'hFC0, 1'b0, 3'b000, '0);
    check("no_read_valid", {31'd0, valid}, 32'd0);

    access(12'hBC1, 1'b0, 3'b001, 32'd1);
    check("pins_write", {31'd0, pins}, 32'd1);
    access(12'hBC1, 1'b0, 3'b011, 32'd1);
    check("pins_clear", {31'd0, pins}, 32'd0);
    access(12'hBC1, 1'b0, 3'b010, 32'd1);
    check("pins_set", {31'd0, pins}, 32'd1);
    access(12'hBC1, 1'b0, 3'b111, 32'd0);
    check("pins_noop", {31'd0, pins}, 32'd1);
    access(12'hBC1, 1'b1, 3'b000, '0);
    check("pins_read", rdata, 32'd1);
    access(12'hBC1, 1'b1, 3'b001, 32'd0);
    check("rmw_old", rdata, 32'd1);
    check("rmw_new", {31'd0, pins}, 32'd0);
    access(12'hFC0, 1'b0, 3'b001, 32'd7);
    access(12'hFC0, 1'b1, 3'b000, '0);
    check("id_readonly", rdata, 32'd1000);

    // instret is 5 here; the user alias is never writable.
    access(12'hC02, 1'b0, 3'b001, 32'hFFFF_FFFF);
    access(12'hC02, 1'b1, 3'b000, '0);
    check("user_ro", rdata, 32'd5);
    access(12'hB02, 1'b0, 3'b001, 32'hFFFF_FFFF);
    @(negedge clk);
    retired = 1'b1;
    @(negedge clk);
    retired = 1'b0;
    access(12'hB02, 1'b1, 3'b000, '0);
`ifdef CSR_COUNTER_WRITE_EN
    check("ctr_wr_lo", rdata, 32'd0);
    access(12'hB82, 1'b1, 3'b000, '0);
    check("ctr_wr_hi", rdata, 32'd1);
`else
    check("ctr_ro_lo", rdata, 32'd6);
    access(12'hB82, 1'b1, 3'b000, '0);
    check("ctr_ro_hi", rdata, 32'd0);
`endif

    // Reset arrives together with a pending read and pin write.
    access(12'hBC1, 1'b0, 3'b001, 32'd1);
    @(negedge clk);
    addr = 12'hBC1;
    @(negedge clk);
    read = 1'b1; modify = 3'b001; wdata = 32'd1; rst = 1'b1;
    @(negedge clk);
    read = 1'b0; modify = '0; wdata = '0;
    check("rst_mid_valid", {31'd0, valid}, 32'd0);
    check("rst_mid_pins", {31'd0, pins}, 32'd0);
    rst = 1'b0;
    access(12'hC00, 1'b1, 3'b000, '0);
    check("rst_cycle", rdata, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
